// File: rtl/axi_pkg.sv
// Shared AXI4-Lite constants plus the 7-segment register map and master status codes.
// Both the seg7 slave and the seg7 master import this package.
package axi_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [31:0] SEG7_REG_DIGITS = 32'h0000_0000;
  localparam logic [31:0] SEG7_REG_DOTS   = 32'h0000_0004;

  typedef enum logic [2:0] {
    SEG7_MST_OK        = 3'd0,
    SEG7_MST_BRESP_ERR = 3'd1,
    SEG7_MST_RRESP_ERR = 3'd2,
    SEG7_MST_MISMATCH  = 3'd3,
    SEG7_MST_TIMEOUT   = 3'd4
  } seg7_mst_status_e;

endpackage

// File: rtl/axi4lite_if.sv
// 32-bit AXI4-Lite bus bundle with master and slave views.
interface axi4lite_if;

  logic [31:0] awaddr;
  logic [2:0]  awprot;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [31:0] araddr;
  logic [2:0]  arprot;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;

  modport master (
    output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
    output araddr, arprot, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
    input  araddr, arprot, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

endinterface

// File: rtl/axil_seg7_master.sv
// AXI4-Lite initiator: one command writes the seg7 digits then dots registers, optionally reads both back.
// Latency: accept-to-done 7 cycles (writes only) or 13 cycles (with readback) against a zero-wait slave.
// Backpressure: cmd_ready is low from accept through done; every AXI phase waits on the slave up to TIMEOUT_CYCLES.
module axil_seg7_master
  import axi_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
  parameter int          DIGITS         = 3,
  parameter bit          READBACK       = 1'b1,
  parameter int          TIMEOUT_CYCLES = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [DIGITS*4-1:0]   cmd_digits,
  input  logic [DIGITS-1:0]     cmd_dots,
  output logic                  done,
  output logic [2:0]            status,
  axi4lite_if.master            axi_if
);

  localparam int             TMO_W    = $clog2(TIMEOUT_CYCLES);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {S_IDLE, S_WR, S_WB, S_RD_A, S_RD_R, S_DONE} state_e;

  state_e              state_q, state_d;
  seg7_mst_status_e    status_q, status_d;
  logic                reg_sel_q;
  logic [DIGITS*4-1:0] dig_q;
  logic [DIGITS-1:0]   dots_q;
  logic                aw_vld_q, w_vld_q, ar_vld_q;
  logic                aw_done_q, w_done_q;
  logic [31:0]         awaddr_q, wdata_q, araddr_q;
  logic [TMO_W-1:0]    tmo_q;
  logic                bready, rready;

  logic aw_hs, w_hs, ar_hs, wr_fin, tmo_hit, waiting, rd_mismatch;

  assign aw_hs   = aw_vld_q && axi_if.awready;
  assign w_hs    = w_vld_q && axi_if.wready;
  assign ar_hs   = ar_vld_q && axi_if.arready;
  assign wr_fin  = (aw_done_q || aw_hs) && (w_done_q || w_hs);
  assign tmo_hit = (tmo_q == TMO_LAST);
  assign waiting = (state_q == S_WR) || (state_q == S_WB) ||
                   (state_q == S_RD_A) || (state_q == S_RD_R);
  // Only the payload bits are compared; the slave may return anything above them.
  assign rd_mismatch = reg_sel_q ? (axi_if.rdata[DIGITS-1:0] != dots_q)
                                 : (axi_if.rdata[DIGITS*4-1:0] != dig_q);

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    status_d  = status_q;
    cmd_ready = 1'b0;
    done      = 1'b0;
    bready    = 1'b0;
    rready    = 1'b0;
    case (state_q)
      S_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          state_d  = S_WR;
          status_d = SEG7_MST_OK;
        end
      end
      S_WR: begin
        if (wr_fin) state_d = S_WB;
        else if (tmo_hit) begin
          state_d  = S_DONE;
          status_d = SEG7_MST_TIMEOUT;
        end
      end
      S_WB: begin
        bready = 1'b1;
        if (axi_if.bvalid) begin
          if (axi_if.bresp != RESP_OKAY) begin
            state_d  = S_DONE;
            status_d = SEG7_MST_BRESP_ERR;
          end else if (!reg_sel_q) state_d = S_WR;
          else if (READBACK)        state_d = S_RD_A;
          else                      state_d = S_DONE;
        end else if (tmo_hit) begin
          state_d  = S_DONE;
          status_d = SEG7_MST_TIMEOUT;
        end
      end
      S_RD_A: begin
        if (ar_hs) state_d = S_RD_R;
        else if (tmo_hit) begin
          state_d  = S_DONE;
          status_d = SEG7_MST_TIMEOUT;
        end
      end
      S_RD_R: begin
        rready = 1'b1;
        if (axi_if.rvalid) begin
          if (axi_if.rresp != RESP_OKAY) begin
            state_d  = S_DONE;
            status_d = SEG7_MST_RRESP_ERR;
          end else if (rd_mismatch) begin
            state_d  = S_DONE;
            status_d = SEG7_MST_MISMATCH;
          end else if (!reg_sel_q) state_d = S_RD_A;
          else                      state_d = S_DONE;
        end else if (tmo_hit) begin
          state_d  = S_DONE;
          status_d = SEG7_MST_TIMEOUT;
        end
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      status_q  <= SEG7_MST_OK;
      reg_sel_q <= 1'b0;
      dig_q     <= '0;
      dots_q    <= '0;
      aw_vld_q  <= 1'b0;
      w_vld_q   <= 1'b0;
      ar_vld_q  <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      awaddr_q  <= '0;
      wdata_q   <= '0;
      araddr_q  <= '0;
      tmo_q     <= '0;
    end else begin
      status_q <= status_d;
      if (state_d != state_q) tmo_q <= '0;
      else if (waiting)       tmo_q <= tmo_q + TMO_W'(1);
      case (state_q)
        S_IDLE: if (cmd_valid) begin
          dig_q     <= cmd_digits;
          dots_q    <= cmd_dots;
          reg_sel_q <= 1'b0;
          awaddr_q  <= BASE_ADDR + SEG7_REG_DIGITS;
          wdata_q   <= 32'(cmd_digits);
          aw_done_q <= 1'b0;
          w_done_q  <= 1'b0;
        end
        S_WR: begin
          // AW and W retire independently; VALIDs go up one cycle after entry.
          if (state_d != S_WR) begin
            aw_vld_q <= 1'b0;
            w_vld_q  <= 1'b0;
          end else begin
            if (aw_hs) begin
              aw_vld_q  <= 1'b0;
              aw_done_q <= 1'b1;
            end else if (!aw_done_q) aw_vld_q <= 1'b1;
            if (w_hs) begin
              w_vld_q  <= 1'b0;
              w_done_q <= 1'b1;
            end else if (!w_done_q) w_vld_q <= 1'b1;
          end
        end
        S_WB: begin
          if (state_d == S_WR) begin
            reg_sel_q <= 1'b1;
            awaddr_q  <= BASE_ADDR + SEG7_REG_DOTS;
            wdata_q   <= 32'(dots_q);
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
          end else if (state_d == S_RD_A) begin
            reg_sel_q <= 1'b0;
            araddr_q  <= BASE_ADDR + SEG7_REG_DIGITS;
          end
        end
        S_RD_A: ar_vld_q <= (state_d == S_RD_A);
        S_RD_R: if (state_d == S_RD_A) begin
          reg_sel_q <= 1'b1;
          araddr_q  <= BASE_ADDR + SEG7_REG_DOTS;
        end
        default: ;
      endcase
    end
  end

  assign status         = status_q;
  assign axi_if.awaddr  = awaddr_q;
  assign axi_if.awprot  = 3'b000;
  assign axi_if.awvalid = aw_vld_q;
  assign axi_if.wdata   = wdata_q;
  assign axi_if.wstrb   = 4'hF;
  assign axi_if.wvalid  = w_vld_q;
  assign axi_if.bready  = bready;
  assign axi_if.araddr  = araddr_q;
  assign axi_if.arprot  = 3'b000;
  assign axi_if.arvalid = ar_vld_q;
  assign axi_if.rready  = rready;

endmodule
